// File: rtl/miner_pkg.sv
// Shared types and widths for the miner datapath: scheduler states,
// hasher word widths and the layout of the 128-bit data word.
package miner_pkg;

    localparam int EPOCH_W_DEFAULT = 2;

    localparam int MIDSTATE_W  = 256;
    localparam int NONCE_W     = 32;
    localparam int DATA_W      = 128;
    // Work tail fills everything below the nonce in the data word.
    localparam int DATA_TAIL_W = DATA_W - NONCE_W;

    localparam int                 STALE_W   = 8;
    localparam logic [STALE_W-1:0] STALE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_e;

    function automatic logic [DATA_W-1:0] pack_data(
        input logic [NONCE_W-1:0]     nonce,
        input logic [DATA_TAIL_W-1:0] tail
    );
        return {nonce, tail};
    endfunction

endpackage

// File: rtl/epoch_filter.sv
// Drops hasher matches whose epoch tag no longer matches the current work;
// forwards the rest as a one-cycle golden pulse and counts the dropped ones.
module epoch_filter
    import miner_pkg::*;
#(
    parameter int EPOCH_W = EPOCH_W_DEFAULT
) (
    input  logic               hash_clk,
    input  logic               reset_n,
    input  logic               result_valid,
    input  logic [NONCE_W-1:0] result_nonce,
    input  logic [EPOCH_W-1:0] result_epoch,
    input  logic [EPOCH_W-1:0] current_epoch,
    output logic               golden_valid,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic [STALE_W-1:0] stale_count
);

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            golden_valid <= 1'b0;
            golden_nonce <= '0;
            stale_count  <= '0;
        end else begin
            golden_valid <= 1'b0;
            if (result_valid) begin
                if (result_epoch == current_epoch) begin
                    golden_valid <= 1'b1;
                    golden_nonce <= result_nonce;
                end else if (stale_count != STALE_MAX) begin
                    stale_count <= stale_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Holds the current work and walks the nonce range one hasher slot at a time,
// tagging every issued nonce with the epoch of the work it belongs to.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
    parameter logic [NONCE_W-1:0] NONCE_END   = 32'hFFFF_FFFF,
    parameter int                 EPOCH_W     = EPOCH_W_DEFAULT
) (
    input  logic                   hash_clk,
    input  logic                   reset_n,
    input  logic                   work_valid,
    input  logic [MIDSTATE_W-1:0]  work_midstate,
    input  logic [DATA_TAIL_W-1:0] work_data,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output logic [MIDSTATE_W-1:0]  state,
    output logic [DATA_W-1:0]      data,
    output logic [EPOCH_W-1:0]     issue_epoch,
    input  logic                   result_valid,
    input  logic [NONCE_W-1:0]     result_nonce,
    input  logic [EPOCH_W-1:0]     result_epoch,
    output logic                   golden_valid,
    output logic [NONCE_W-1:0]     golden_nonce,
    output logic                   exhausted,
    output logic [STALE_W-1:0]     stale_count
);

    sched_state_e       fsm_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               handshake;

    assign handshake = issue_valid && issue_ready;

    // New work outranks a same-cycle handshake: the hasher still takes the
    // nonce and epoch presented this cycle, but no increment is applied.
    // NOTE: non-blocking assignments make every register below update from
    // pre-edge values, so the epoch seen by the filter is the old one.
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            fsm_q       <= SCHED_IDLE;
            issue_valid <= 1'b0;
            exhausted   <= 1'b0;
            state       <= '0;
            data        <= '0;
            nonce_q     <= NONCE_START;
            issue_epoch <= '0;
        end else if (work_valid) begin
            fsm_q       <= SCHED_RUN;
            issue_valid <= 1'b1;
            exhausted   <= 1'b0;
            state       <= work_midstate;
            data        <= pack_data(NONCE_START, work_data);
            nonce_q     <= NONCE_START;
            issue_epoch <= issue_epoch + 1'b1;
        end else if (fsm_q == SCHED_RUN && handshake) begin
            if (nonce_q == NONCE_END) begin
                fsm_q       <= SCHED_DONE;
                issue_valid <= 1'b0;
                exhausted   <= 1'b1;
            end else begin
                nonce_q                 <= nonce_q + 32'd1;
                data[DATA_W-1:DATA_TAIL_W] <= nonce_q + 32'd1;
            end
        end
    end

    epoch_filter #(
        .EPOCH_W (EPOCH_W)
    ) u_epoch_filter (
        .hash_clk      (hash_clk),
        .reset_n       (reset_n),
        .result_valid  (result_valid),
        .result_nonce  (result_nonce),
        .result_epoch  (result_epoch),
        .current_epoch (issue_epoch),
        .golden_valid  (golden_valid),
        .golden_nonce  (golden_nonce),
        .stale_count   (stale_count)
    );

endmodule
